// File: rtl/decoder_mon_pkg.sv
// Shared constants and types for the Decoder1 dual-rail bus monitor:
// rail positions, folding geometry, MISR polynomial and the recovered-field struct.
package decoder_mon_pkg;

   localparam int PAIRS       = 13;
   localparam int A_W         = 2 * PAIRS;
   localparam int D_W         = 107;
   localparam int W_W         = 41;
   localparam int X_W         = 69;
   localparam int FOLD_IN_W   = D_W + W_W + X_W;
   localparam int FOLD_CHUNKS = 7;

   localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

   // Index of the true rail of each field; the complement sits one bit below.
   localparam int INTR_RAIL   = 1;
   localparam int CB_RAIL     = 3;
   localparam int IR_RAIL0    = 5;
   localparam int STATE_RAIL0 = 21;

   typedef struct packed {
      logic       intr;
      logic       cb;
      logic [7:0] ir;
      logic [2:0] state;
   } fields_t;

   typedef logic [9:0] key_t;

   function automatic key_t key_of(input fields_t f);
      return {f.intr, f.cb, f.ir};
   endfunction

endpackage

// File: rtl/decoder_sig_misr.sv
// MISR over the decoder outputs: the {x,w,d} word is XOR-folded into 32 bits
// and mixed into a left-shifting CRC-32 style register.
module decoder_sig_misr
   import decoder_mon_pkg::*;
#(
   parameter int SIG_W = 32
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 en,
   input  logic                 clear,
   input  logic [FOLD_IN_W-1:0] din,
   output logic [SIG_W-1:0]     sig
);

   logic [32*FOLD_CHUNKS-1:0] padded;
   logic [31:0]               chunk [FOLD_CHUNKS];
   logic [31:0]               fold;
   logic [SIG_W-1:0]          sig_reg;
   logic [SIG_W-1:0]          sig_next;

   assign padded = {{(32*FOLD_CHUNKS-FOLD_IN_W){1'b0}}, din};

   generate
      for (genvar gi = 0; gi < FOLD_CHUNKS; gi++) begin : g_chunk
         assign chunk[gi] = padded[32*gi +: 32];
      end
   endgenerate

   always_comb begin
      fold = '0;
      for (int i = 0; i < FOLD_CHUNKS; i++) begin
         fold = fold ^ chunk[i];
      end
      sig_next = {sig_reg[SIG_W-2:0], 1'b0}
               ^ (sig_reg[SIG_W-1] ? MISR_POLY[SIG_W-1:0] : '0)
               ^ fold[SIG_W-1:0];
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sig_reg <= '0;
      end else if (clear) begin
         sig_reg <= '0;
      end else if (en) begin
         sig_reg <= sig_next;
      end
   end

   assign sig = sig_reg;

endmodule

// File: rtl/decoder_abus_monitor.sv
// Receive-side monitor for the Decoder1 dual-rail bus: pair checking, field
// recovery, opcode-boundary tracking and a MISR over the d/w/x outputs.
module decoder_abus_monitor
   import decoder_mon_pkg::*;
#(
   parameter int SIG_W    = 32,
   parameter int ERRCNT_W = 8,
   parameter int STEP_W   = 4
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                en,
   input  logic                clear,
   input  logic [A_W-1:0]      a,
   input  logic [D_W-1:0]      d,
   input  logic [W_W-1:0]      w,
   input  logic [X_W-1:0]      x,
   output logic                intr,
   output logic                cb,
   output logic [7:0]          ir,
   output logic [2:0]          state,
   output logic                fields_valid,
   output logic [PAIRS-1:0]    pair_err_mask,
   output logic [ERRCNT_W-1:0] err_cnt,
   output logic                opcode_done,
   output logic [STEP_W-1:0]   step_cnt,
   output logic [SIG_W-1:0]    signature
);

   logic [PAIRS-1:0]    bad;
   logic                sample_ok;
   fields_t             sample_f;
   key_t                sample_key;

   fields_t             fields_reg;
   logic                fields_valid_reg;
   logic [PAIRS-1:0]    mask_reg;
   logic [ERRCNT_W-1:0] err_cnt_reg;
   logic                done_reg;
   logic [STEP_W-1:0]   step_cnt_reg;
   logic                have_key_reg;
   key_t                key_reg;
   logic [STEP_W-1:0]   run_cnt_reg;

   generate
      for (genvar gi = 0; gi < PAIRS; gi++) begin : g_pair
         assign bad[gi] = (a[2*gi] == a[2*gi+1]);
      end
      for (genvar gi = 0; gi < 8; gi++) begin : g_ir
         assign sample_f.ir[7-gi] = a[IR_RAIL0 + 2*gi];
      end
      for (genvar gi = 0; gi < 3; gi++) begin : g_state
         assign sample_f.state[2-gi] = a[STATE_RAIL0 + 2*gi];
      end
   endgenerate

   assign sample_f.intr = a[INTR_RAIL];
   assign sample_f.cb   = a[CB_RAIL];
   assign sample_ok     = ~|bad;
   assign sample_key    = key_of(sample_f);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         fields_reg       <= '0;
         fields_valid_reg <= 1'b0;
         mask_reg         <= '0;
         err_cnt_reg      <= '0;
         done_reg         <= 1'b0;
         step_cnt_reg     <= '0;
         have_key_reg     <= 1'b0;
         key_reg          <= '0;
         run_cnt_reg      <= '0;
      end else if (clear) begin
         // Recovered fields and the last step count deliberately survive a clear.
         fields_valid_reg <= 1'b0;
         mask_reg         <= '0;
         err_cnt_reg      <= '0;
         done_reg         <= 1'b0;
         have_key_reg     <= 1'b0;
         run_cnt_reg      <= '0;
      end else if (en) begin
         done_reg <= 1'b0;
         mask_reg <= mask_reg | bad;
         if (!sample_ok) begin
            fields_valid_reg <= 1'b0;
            if (err_cnt_reg != '1) begin
               err_cnt_reg <= err_cnt_reg + 1'b1;
            end
         end else begin
            fields_valid_reg <= 1'b1;
            fields_reg       <= sample_f;
            if (!have_key_reg) begin
               have_key_reg <= 1'b1;
               key_reg      <= sample_key;
               run_cnt_reg  <= STEP_W'(1);
            end else if (sample_key == key_reg) begin
               if (run_cnt_reg != '1) begin
                  run_cnt_reg <= run_cnt_reg + 1'b1;
               end
            end else begin
               done_reg     <= 1'b1;
               step_cnt_reg <= run_cnt_reg;
               key_reg      <= sample_key;
               run_cnt_reg  <= STEP_W'(1);
            end
         end
      end else begin
         done_reg <= 1'b0;
      end
   end

   decoder_sig_misr #(
      .SIG_W (SIG_W)
   ) u_misr (
      .CLK   (CLK),
      .RESET (RESET),
      .en    (en && sample_ok),
      .clear (clear),
      .din   ({x, w, d}),
      .sig   (signature)
   );

   assign intr          = fields_reg.intr;
   assign cb            = fields_reg.cb;
   assign ir            = fields_reg.ir;
   assign state         = fields_reg.state;
   assign fields_valid  = fields_valid_reg;
   assign pair_err_mask = mask_reg;
   assign err_cnt       = err_cnt_reg;
   assign opcode_done   = done_reg;
   assign step_cnt      = step_cnt_reg;

endmodule

// File: tb/tb_decoder_abus_monitor.sv
// Directed bench for decoder_abus_monitor: field recovery, pair errors,
// MISR values, opcode boundaries, clear priority and asynchronous reset.
module tb_decoder_abus_monitor;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         en;
   logic         clear;
   logic [25:0]  a;
   logic [106:0] d;
   logic [40:0]  w;
   logic [68:0]  x;
   logic         intr;
   logic         cb;
   logic [7:0]   ir;
   logic [2:0]   state;
   logic         fields_valid;
   logic [12:0]  pair_err_mask;
   logic [7:0]   err_cnt;
   logic         opcode_done;
   logic [3:0]   step_cnt;
   logic [31:0]  signature;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 CLK = ~CLK;

   decoder_abus_monitor dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .en            (en),
      .clear         (clear),
      .a             (a),
      .d             (d),
      .w             (w),
      .x             (x),
      .intr          (intr),
      .cb            (cb),
      .ir            (ir),
      .state         (state),
      .fields_valid  (fields_valid),
      .pair_err_mask (pair_err_mask),
      .err_cnt       (err_cnt),
      .opcode_done   (opcode_done),
      .step_cnt      (step_cnt),
      .signature     (signature)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Dual-rail encoder: true rail at odd index, complement just below it.
   function automatic logic [25:0] mk_a(input logic fi, input logic fc,
                                        input logic [7:0] fir, input logic [2:0] fst);
      logic [12:0] t;
      logic [25:0] r;
      t[0] = fi;
      t[1] = fc;
      for (int k = 0; k < 8; k++) t[2+k] = fir[7-k];
      t[10] = fst[2];
      t[11] = fst[1];
      t[12] = fst[0];
      for (int k = 0; k < 13; k++) begin
         r[2*k+1] = t[k];
         r[2*k]   = ~t[k];
      end
      return r;
   endfunction

   task automatic do_sample(input logic [25:0] av, input logic [106:0] dv,
                            input logic [40:0] wv, input logic [68:0] xv, input logic clr);
      a = av; d = dv; w = wv; x = xv; en = 1'b1; clear = clr;
      @(posedge CLK);
      #1;
      en = 1'b0; clear = 1'b0;
      $display("sample a=%h clr=%b -> ir=%h st=%0d fv=%b mask=%h err=%0d done=%b step=%0d sig=%h",
               av, clr, ir, state, fields_valid, pair_err_mask, err_cnt, opcode_done, step_cnt, signature);
   endtask

   task automatic idle_cycle(input logic clr);
      en = 1'b0; clear = clr;
      @(posedge CLK);
      #1;
      clear = 1'b0;
      $display("idle clr=%b -> done=%b step=%0d mask=%h err=%0d sig=%h",
               clr, opcode_done, step_cnt, pair_err_mask, err_cnt, signature);
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_intr"}, intr, 0);
      check({pfx, "_cb"}, cb, 0);
      check({pfx, "_ir"}, ir, 0);
      check({pfx, "_state"}, state, 0);
      check({pfx, "_fv"}, fields_valid, 0);
      check({pfx, "_mask"}, pair_err_mask, 0);
      check({pfx, "_err"}, err_cnt, 0);
      check({pfx, "_done"}, opcode_done, 0);
      check({pfx, "_step"}, step_cnt, 0);
      check({pfx, "_sig"}, signature, 0);
   endtask

   logic [25:0]  av;
   logic [106:0] dv;
   logic [40:0]  wv;
   logic [68:0]  xv;
   int           pulses;
   int           pulse_idx;
   logic [3:0]   pulse_step;

   initial begin
      RESET = 1'b1; en = 1'b0; clear = 1'b0;
      a = '0; d = '0; w = '0; x = '0;
      repeat (2) @(posedge CLK);
      #3;
      check_all_zero("rst");
      RESET = 1'b0;
      @(negedge CLK);

      // First sample: IR=0x0A, state=1
      av = mk_a(1'b0, 1'b0, 8'h0A, 3'b001);
      do_sample(av, '0, '0, '0, 1'b0);
      check("first_ir", ir, 8'h0A);
      check("first_state", state, 3'd1);
      check("first_fv", fields_valid, 1);
      check("first_sig", signature, 0);
      check("first_mask", pair_err_mask, 0);
      check("first_done", opcode_done, 0);

      // d[0]=1 twice
      dv = '0; dv[0] = 1'b1;
      do_sample(av, dv, '0, '0, 1'b0);
      check("sig_d0_1", signature, 32'h00000001);
      do_sample(av, dv, '0, '0, 1'b0);
      check("sig_d0_2", signature, 32'h00000003);
      check("same_key_done", opcode_done, 0);

      // Bad pair 2 (a[4]=a[5]=1)
      av = mk_a(1'b0, 1'b0, 8'h0A, 3'b001);
      av[4] = 1'b1; av[5] = 1'b1;
      do_sample(av, dv, '0, '0, 1'b0);
      check("bad_mask", pair_err_mask, 13'h0004);
      check("bad_err", err_cnt, 1);
      check("bad_fv", fields_valid, 0);
      check("bad_ir", ir, 8'h0A);
      check("bad_sig_hold", signature, 32'h00000003);
      for (int i = 1; i < 300; i++) do_sample(av, dv, '0, '0, 1'b0);
      check("err_sat", err_cnt, 255);

      // New key after 3 valid samples of IR 0x0A
      av = mk_a(1'b0, 1'b0, 8'h0B, 3'b010);
      do_sample(av, '0, '0, '0, 1'b0);
      check("key_change_done", opcode_done, 1);
      check("key_change_step", step_cnt, 3);
      check("key_change_fv", fields_valid, 1);
      idle_cycle(1'b0);
      check("idle_done", opcode_done, 0);
      check("idle_step_hold", step_cnt, 3);

      // clear + en with a bad pair on the same edge
      av = mk_a(1'b1, 1'b0, 8'h0C, 3'b000);
      av[0] = av[1];
      do_sample(av, '0, '0, '0, 1'b1);
      check("clr_mask", pair_err_mask, 0);
      check("clr_err", err_cnt, 0);
      check("clr_sig", signature, 0);
      check("clr_done", opcode_done, 0);
      check("clr_ir_hold", ir, 8'h0B);
      check("clr_step_hold", step_cnt, 3);
      av = mk_a(1'b0, 1'b1, 8'h0C, 3'b000);
      do_sample(av, '0, '0, '0, 1'b0);
      check("after_clr_done", opcode_done, 0);
      check("after_clr_ir", ir, 8'h0C);
      check("after_clr_cb", cb, 1);

      // Fold and polynomial
      dv = '0; dv[0] = 1'b1; dv[32] = 1'b1; wv = '0; wv[0] = 1'b1;
      do_sample(av, dv, wv, '0, 1'b0);
      check("fold_w0", signature, 32'h00000800);
      dv = '0; dv[31] = 1'b1;
      do_sample(av, dv, '0, '0, 1'b0);
      check("fold_d31", signature, 32'h80001000);
      do_sample(av, '0, '0, '0, 1'b0);
      check("poly_fb", signature, 32'h04C13DB7);
      xv = '0; xv[0] = 1'b1;
      do_sample(av, '0, '0, xv, 1'b0);
      check("fold_x0", signature, 32'h09927B6E);

      // Sweep 0..63: IR = i/32, state = i[4:2]
      idle_cycle(1'b1);
      pulses = 0; pulse_idx = -1; pulse_step = '0;
      for (int i = 0; i < 64; i++) begin
         av = mk_a(1'b0, 1'b0, 8'(i >> 5), 3'((i >> 2) & 7));
         do_sample(av, '0, '0, '0, 1'b0);
         if (opcode_done) begin
            pulses++;
            pulse_idx = i;
            pulse_step = step_cnt;
         end
      end
      check("sweep_pulses", pulses, 1);
      check("sweep_pulse_idx", pulse_idx, 32);
      check("sweep_step_sat", pulse_step, 15);

      // Async reset between edges mid-sweep
      dv = '0; dv[5] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         av = mk_a(1'b0, 1'b0, 8'(i >> 5), 3'((i >> 2) & 7));
         do_sample(av, dv, '0, '0, 1'b0);
      end
      av[2] = av[3];
      do_sample(av, dv, '0, '0, 1'b0);
      check("pre_rst_err", err_cnt, 1);
      #2;
      RESET = 1'b1;
      #1;
      check_all_zero("async_rst");
      #2;
      RESET = 1'b0;
      av = mk_a(1'b1, 1'b0, 8'h33, 3'b101);
      do_sample(av, '0, '0, '0, 1'b0);
      check("post_rst_done", opcode_done, 0);
      check("post_rst_fv", fields_valid, 1);
      check("post_rst_intr", intr, 1);
      check("post_rst_state", state, 3'd5);
      av = mk_a(1'b1, 1'b0, 8'h34, 3'b101);
      do_sample(av, '0, '0, '0, 1'b0);
      check("post_rst_key_done", opcode_done, 1);
      check("post_rst_key_step", step_cnt, 1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
